// File: rtl/hamming74_decoder_pipe.sv
// Two-stage streaming Hamming(7,4) decoder: syndrome in S1, correction in S2, full valid/ready backpressure.
// Optional saturating word/error counters are built only when HAMMING_DEC_STATS_EN is defined.
module hamming74_decoder_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic [2:0]       out_syndrome,
    output logic             out_corrected,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] word_count
);

    function automatic logic [2:0] calc_syndrome(input logic [6:0] c);
        logic [2:0] s;
        s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
        s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
        s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
        return s;
    endfunction

    // Only syndromes naming a data position (3,5,6,7) change the data; parity-bit hits leave it intact.
    function automatic logic [3:0] correct_data(input logic [3:0] d, input logic [2:0] syn);
        logic [3:0] flip;
        case (syn)
            3'd3:    flip = 4'b0001;
            3'd5:    flip = 4'b0010;
            3'd6:    flip = 4'b0100;
            3'd7:    flip = 4'b1000;
            default: flip = 4'b0000;
        endcase
        return d ^ flip;
    endfunction

    logic       s1_valid_r;
    logic [3:0] s1_data_r;
    logic [2:0] s1_syn_r;
    logic       s2_valid_r;
    logic [3:0] s2_data_r;
    logic [2:0] s2_syn_r;
    logic       s2_corr_r;
    logic       s2_adv_s;
    logic       s1_adv_s;

    assign s2_adv_s = !s2_valid_r || out_ready;
    assign s1_adv_s = !s1_valid_r || s2_adv_s;
    assign in_ready = s1_adv_s;

    // Pipeline stages: each stage loads whenever it may advance, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= 4'd0;
            s1_syn_r   <= 3'd0;
            s2_valid_r <= 1'b0;
            s2_data_r  <= 4'd0;
            s2_syn_r   <= 3'd0;
            s2_corr_r  <= 1'b0;
        end else begin
            if (s1_adv_s) begin
                s1_valid_r <= in_valid;
                if (in_valid) begin
                    s1_data_r <= {in_code[6], in_code[5], in_code[4], in_code[2]};
                    s1_syn_r  <= calc_syndrome(in_code);
                end
            end
            if (s2_adv_s) begin
                s2_valid_r <= s1_valid_r;
                if (s1_valid_r) begin
                    s2_data_r <= correct_data(s1_data_r, s1_syn_r);
                    s2_syn_r  <= s1_syn_r;
                    s2_corr_r <= (s1_syn_r != 3'd0);
                end
            end
        end
    end

    assign out_valid     = s2_valid_r;
    assign out_data      = s2_data_r;
    assign out_syndrome  = s2_syn_r;
    assign out_corrected = s2_corr_r;

`ifdef HAMMING_DEC_STATS_EN
    logic [CNT_W-1:0] word_cnt_r;
    logic [CNT_W-1:0] err_cnt_r;
    logic             out_xfer_s;

    assign out_xfer_s = s2_valid_r && out_ready;

    // Saturating statistics, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_r <= {CNT_W{1'b0}};
            err_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (out_xfer_s && (word_cnt_r != {CNT_W{1'b1}})) begin
                word_cnt_r <= word_cnt_r + CNT_W'(1);
            end
            if (out_xfer_s && s2_corr_r && (err_cnt_r != {CNT_W{1'b1}})) begin
                err_cnt_r <= err_cnt_r + CNT_W'(1);
            end
        end
    end

    assign word_count = word_cnt_r;
    assign err_count  = err_cnt_r;
`else
    assign word_count = {CNT_W{1'b0}};
    assign err_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hamming74_decoder_pipe.sv
// Randomized self-checking bench for hamming74_decoder_pipe against a position-based Hamming reference model.
// Counter expectations follow HAMMING_DEC_STATS_EN when it is defined.
module tb_hamming74_decoder_pipe;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [6:0]       in_code = 7'd0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [3:0]       out_data;
    logic [2:0]       out_syndrome;
    logic             out_corrected;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] word_count;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    int         occ;
    bit         in_fire;
    bit         out_fire;
    bit         pop_ok;
    logic [7:0] popped;
    int         word_m = 0;
    int         err_m  = 0;

    hamming74_decoder_pipe #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_syndrome(out_syndrome), .out_corrected(out_corrected),
        .err_count(err_count), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Parity bit at position 2^k covers every other position whose index has bit k set.
    function automatic logic [6:0] model_encode(input logic [3:0] d);
        logic [6:0] c;
        logic       p;
        c = 7'd0;
        c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
        for (int k = 0; k < 3; k++) begin
            p = 1'b0;
            for (int i = 0; i < 7; i++)
                if ((((i + 1) >> k) & 1) == 1 && (i + 1) != (1 << k)) p = p ^ c[i];
            c[(1 << k) - 1] = p;
        end
        return c;
    endfunction

    // Syndrome is the XOR of the 1-based positions of all set bits; returns {corr, syn, data}.
    function automatic logic [7:0] model_decode(input logic [6:0] code);
        int         s;
        logic [6:0] f;
        s = 0;
        for (int i = 0; i < 7; i++) if (code[i]) s = s ^ (i + 1);
        f = code;
        if (s != 0) f[s - 1] = ~f[s - 1];
        return {(s != 0), 3'(s), f[6], f[5], f[4], f[2]};
    endfunction

    task automatic step(input logic v, input logic [6:0] code, input logic ordy);
        @(negedge clk);
        in_valid  = v;
        in_code   = code;
        out_ready = ordy;
        #1;
        occ      = exp_q.size();
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        pop_ok   = 1'b0;
        if (out_fire && exp_q.size() != 0) begin
            popped = exp_q.pop_front();
            pop_ok = 1'b1;
`ifdef HAMMING_DEC_STATS_EN
            if (word_m < CNT_MAX) word_m++;
            if (popped[7] && err_m < CNT_MAX) err_m++;
`endif
        end
        if (in_fire) exp_q.push_back(model_decode(code));
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_code = 7'd0; out_ready = 1'b0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        word_m = 0;
        err_m  = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset(3);
        n_checks++;
        if ({out_valid, in_ready, out_data, out_syndrome, out_corrected} !== 10'b01_0000_000_0)
            $display("FAIL reset_state: got %b want 0100000000",
                     {out_valid, in_ready, out_data, out_syndrome, out_corrected});
        else n_pass++;
        n_checks++;
        if (word_count !== CNT_W'(0) || err_count !== CNT_W'(0))
            $display("FAIL reset_counters: got word=%0d err=%0d want 0/0", word_count, err_count);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [6:0] codes [3] = '{7'h55, 7'h45, 7'h01};
        logic [7:0] want  [3] = '{{1'b0, 3'd0, 4'b1011}, {1'b1, 3'd5, 4'b1011}, {1'b1, 3'd1, 4'b0000}};
        for (int t = 0; t < 3; t++) begin
            step(1'b1, codes[t], 1'b1);
            n_checks++;
            if (in_fire !== 1'b1) $display("FAIL directed_accept[%0d]: in_ready=%b want 1", t, in_ready);
            else n_pass++;
            step(1'b0, 7'd0, 1'b1);
            n_checks++;
            if (out_valid !== 1'b0) $display("FAIL directed_latency_early[%0d]: out_valid=%b want 0", t, out_valid);
            else n_pass++;
            step(1'b0, 7'd0, 1'b1);
            n_checks++;
            if ({out_valid, out_corrected, out_syndrome, out_data} !== {1'b1, want[t]})
                $display("FAIL directed_word[%0d]: got v=%b c=%b s=%0d d=%b want v=1 c=%b s=%0d d=%b", t,
                         out_valid, out_corrected, out_syndrome, out_data, want[t][7], want[t][6:4], want[t][3:0]);
            else n_pass++;
            n_checks++;
            if (!pop_ok || popped !== want[t])
                $display("FAIL directed_model[%0d]: model=%h want %h", t, popped, want[t]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [6:0] codes [16];
        int         sent = 0;
        int         got  = 0;
        int         cyc  = 0;
        bit         stall_prev = 1'b0;
        logic [8:0] held = 9'd0;
        logic       ordy;
        for (int i = 0; i < 16; i++) begin
            codes[i] = model_encode(4'(i));
            if ($urandom_range(0, 1) == 1) codes[i][$urandom_range(0, 6)] ^= 1'b1;
        end
        while (got < 16 && cyc < 2000) begin
            ordy = 1'($urandom_range(0, 1));
            if (sent < 16) step(1'b1, codes[sent], ordy);
            else step(1'b0, 7'd0, ordy);
            cyc++;
            n_checks++;
            if (in_ready !== !(occ == 2 && !ordy))
                $display("FAIL bp_in_ready: cyc %0d occ %0d out_ready %b in_ready=%b", cyc, occ, ordy, in_ready);
            else n_pass++;
            if (stall_prev) begin
                n_checks++;
                if ({out_valid, out_corrected, out_syndrome, out_data} !== held)
                    $display("FAIL bp_stable: cyc %0d got %h want %h", cyc,
                             {out_valid, out_corrected, out_syndrome, out_data}, held);
                else n_pass++;
            end
            if (occ == 2) begin
                n_checks++;
                if (out_valid !== 1'b1) $display("FAIL bp_full_valid: cyc %0d out_valid=%b want 1", cyc, out_valid);
                else n_pass++;
            end
            if (out_fire) begin
                n_checks++;
                if (!pop_ok || {out_corrected, out_syndrome, out_data} !== popped)
                    $display("FAIL bp_word[%0d]: got %h want %h", got,
                             {out_corrected, out_syndrome, out_data}, popped);
                else n_pass++;
                got++;
            end
            if (in_fire) sent++;
            stall_prev = out_valid && !ordy;
            held       = {out_valid, out_corrected, out_syndrome, out_data};
        end
        n_checks++;
        if (got != 16 || exp_q.size() != 0)
            $display("FAIL bp_delivered: got %0d words (%0d pending) want 16 (0)", got, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        logic [6:0] code;
        step(1'b1, model_encode(4'd9), 1'b0);
        step(1'b1, model_encode(4'd6), 1'b0);
        step(1'b1, model_encode(4'd3), 1'b0);
        n_checks++;
        if (occ != 2 || in_ready !== 1'b0 || out_valid !== 1'b1)
            $display("FAIL mid_full: occ %0d in_ready=%b out_valid=%b want 2/0/1", occ, in_ready, out_valid);
        else n_pass++;
        do_reset(1);
        n_checks++;
        if ({out_valid, in_ready, out_data, out_syndrome, out_corrected} !== 10'b01_0000_000_0)
            $display("FAIL mid_reset_state: got %b want 0100000000",
                     {out_valid, in_ready, out_data, out_syndrome, out_corrected});
        else n_pass++;
        n_checks++;
        if (word_count !== CNT_W'(0) || err_count !== CNT_W'(0))
            $display("FAIL mid_reset_counters: got word=%0d err=%0d want 0/0", word_count, err_count);
        else n_pass++;
        code = model_encode(4'(($urandom_range(0, 15))));
        code[$urandom_range(0, 6)] ^= 1'b1;
        step(1'b1, code, 1'b1);
        step(1'b0, 7'd0, 1'b1);
        step(1'b0, 7'd0, 1'b1);
        n_checks++;
        if (!out_fire || {out_corrected, out_syndrome, out_data} !== model_decode(code))
            $display("FAIL mid_next_word: v=%b got %h want %h", out_valid,
                     {out_corrected, out_syndrome, out_data}, model_decode(code));
        else n_pass++;
    endtask

    task automatic test_stats();
        logic [6:0] code;
        int         exp_cnt;
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            code = model_encode(4'($urandom_range(0, 15)));
            code[$urandom_range(0, 6)] ^= 1'b1;
            step(1'b1, code, 1'b1);
        end
        repeat (3) step(1'b0, 7'd0, 1'b1);
        step(1'b0, 7'd0, 1'b0);
        exp_cnt = (5 < CNT_MAX) ? 5 : CNT_MAX;
`ifndef HAMMING_DEC_STATS_EN
        exp_cnt = 0;
`endif
        n_checks++;
        if (word_count !== CNT_W'(exp_cnt) || word_m != exp_cnt)
            $display("FAIL stats_word: got %0d want %0d", word_count, exp_cnt);
        else n_pass++;
        n_checks++;
        if (err_count !== CNT_W'(exp_cnt) || err_m != exp_cnt)
            $display("FAIL stats_err: got %0d want %0d", err_count, exp_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midstream();
        test_stats();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
